// File: rtl/instruction_memory_loader.sv
// Boot-time instruction memory loader: packs a big-endian byte stream into words,
// writes them at consecutive word-aligned addresses and verifies a trailing checksum word.
module instruction_memory_loader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 100
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Loader_Start,
  input  logic [15:0]      Loader_Length,
  input  logic [7:0]       Loader_ByteIn,
  input  logic             Loader_ByteValid,
  output logic             Loader_ByteReady,
  output logic             Loader_WrEn,
  output logic [WIDTH-1:0] Loader_WrAddr,
  output logic [WIDTH-1:0] Loader_WrData,
  output logic             Loader_Busy,
  output logic             Loader_Done,
  output logic             Loader_Error
);

  localparam int unsigned Lanes = WIDTH / 8;
  localparam int unsigned BcW   = (Lanes > 1) ? $clog2(Lanes) : 1;

  localparam logic [BcW-1:0]   LastLane = BcW'(Lanes - 1);
  localparam logic [15:0]      DepthLen = 16'(DEPTH);
  localparam logic [WIDTH-1:0] AddrStep = WIDTH'(Lanes);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRecv  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StCsum  = 3'd3;
  localparam logic [2:0] StFin   = 3'd4;
  localparam logic [2:0] StFail  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [BcW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [15:0]      len_q, len_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             error_q, error_d;

  logic             byte_ready;
  logic             byte_fire;
  logic [WIDTH-1:0] word_shifted;

  assign byte_ready   = (state_q == StRecv) || (state_q == StCsum);
  assign byte_fire    = byte_ready && Loader_ByteValid;
  // Earlier bytes move toward the MSB, so the first byte ends up in the top lane.
  assign word_shifted = {word_q[WIDTH-9:0], Loader_ByteIn};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    word_d     = word_q;
    sum_d      = sum_q;
    error_d    = error_q;

    case (state_q)
      StIdle: begin
        if (Loader_Start) begin
          if ((Loader_Length != 16'd0) && (Loader_Length <= DepthLen)) begin
            state_d    = StRecv;
            len_d      = Loader_Length;
            error_d    = 1'b0;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            addr_d     = '0;
            sum_d      = '0;
          end else begin
            state_d = StFail;
            error_d = 1'b1;
          end
        end
      end
      StRecv, StCsum: begin
        if (byte_fire) begin
          word_d     = word_shifted;
          byte_cnt_d = byte_cnt_q + BcW'(1);
          if (byte_cnt_q == LastLane) begin
            byte_cnt_d = '0;
            if (state_q == StRecv) begin
              state_d = StWrite;
            end else begin
              state_d = StFin;
              error_d = (word_shifted != sum_q);
            end
          end
        end
      end
      StWrite: begin
        sum_d      = sum_q + word_q;
        addr_d     = addr_q + AddrStep;
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = ((word_cnt_q + 16'd1) == len_q) ? StCsum : StRecv;
      end
      StFin, StFail: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      error_q    <= error_d;
    end
  end

  assign Loader_ByteReady = byte_ready;
  assign Loader_WrEn      = (state_q == StWrite);
  assign Loader_WrAddr    = addr_q;
  assign Loader_WrData    = word_q;
  assign Loader_Busy      = (state_q == StRecv) || (state_q == StWrite) || (state_q == StCsum);
  assign Loader_Done      = (state_q == StFin) || (state_q == StFail);
  assign Loader_Error     = error_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomized scoreboard bench for instruction_memory_loader: a driver pushes expected
// writes and completions, a negedge monitor pops and compares them.
module tb_instruction_memory_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Loader_Start;
  logic [15:0] Loader_Length;
  logic [7:0]  Loader_ByteIn;
  logic        Loader_ByteValid;
  logic        Loader_ByteReady;
  logic        Loader_WrEn;
  logic [31:0] Loader_WrAddr;
  logic [31:0] Loader_WrData;
  logic        Loader_Busy;
  logic        Loader_Done;
  logic        Loader_Error;

  always #5 CLK = ~CLK;

  instruction_memory_loader #(
    .WIDTH(32),
    .DEPTH(100)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .Loader_Start    (Loader_Start),
    .Loader_Length   (Loader_Length),
    .Loader_ByteIn   (Loader_ByteIn),
    .Loader_ByteValid(Loader_ByteValid),
    .Loader_ByteReady(Loader_ByteReady),
    .Loader_WrEn     (Loader_WrEn),
    .Loader_WrAddr   (Loader_WrAddr),
    .Loader_WrData   (Loader_WrData),
    .Loader_Busy     (Loader_Busy),
    .Loader_Done     (Loader_Done),
    .Loader_Error    (Loader_Error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic        exp_done[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned done_cyc = 0;
  int          done_seen = 0;
  logic [31:0] last_wr_addr = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string info);
    checks++;
    failures++;
    $display("FAIL %s %s", name, info);
  endtask

  // Monitor: every write and every completion must match the head of its queue.
  always @(negedge CLK) begin
    if (!RST) begin
      if (Loader_WrEn) begin
        check("ready_low_in_write", 32'(Loader_ByteReady), 32'd0);
        last_wr_addr = Loader_WrAddr;
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_write", $sformatf("addr=0x%08h data=0x%08h required=none",
                                                 Loader_WrAddr, Loader_WrData));
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", Loader_WrAddr, e.addr);
          check("wr_data", Loader_WrData, e.data);
        end
      end
      if (Loader_Done) begin
        done_seen++;
        done_cyc = cyc;
        check("busy_low_at_done", 32'(Loader_Busy), 32'd0);
        if (exp_done.size() == 0) begin
          fail_now("unexpected_done", "actual=done required=none");
        end else begin
          logic e_err;
          e_err = exp_done.pop_front();
          check("error_at_done", 32'(Loader_Error), 32'(e_err));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int valid_pct);
    logic fire;
    int   n;
    fire = 1'b0;
    n    = 0;
    while (!fire && n < 1000) begin
      Loader_ByteValid = ($urandom_range(99) < valid_pct);
      Loader_ByteIn    = Loader_ByteValid ? b : 8'($urandom);
      // Start/Length noise while busy must be ignored.
      Loader_Start     = $urandom_range(3) == 0;
      Loader_Length    = 16'($urandom);
      @(negedge CLK);
      fire = Loader_ByteValid && Loader_ByteReady;
      @(posedge CLK);
      #1;
      n++;
    end
    Loader_ByteValid = 1'b0;
    Loader_Start     = 1'b0;
    if (!fire) fail_now("byte_timeout", $sformatf("byte=0x%02h not accepted", b));
  endtask

  task automatic send_word(input logic [31:0] w, input int valid_pct);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], valid_pct);
  endtask

  task automatic run_load(input int len, input logic [31:0] words[$], input logic [31:0] csum,
                          input int valid_pct, input logic exp_err, output int lat);
    int          d0;
    int unsigned s_cyc;
    lat = 0;
    @(posedge CLK);
    #1;
    Loader_Start  = 1'b1;
    Loader_Length = 16'(len);
    @(posedge CLK);
    #1;
    Loader_Start  = 1'b0;
    Loader_Length = 16'($urandom);
    s_cyc = cyc;
    check("busy_after_start", 32'(Loader_Busy), 32'd1);
    check("ready_after_start", 32'(Loader_ByteReady), 32'd1);
    check("error_cleared_on_start", 32'(Loader_Error), 32'd0);
    for (int k = 0; k < len; k++) begin
      send_word(words[k], valid_pct);
      exp_wr.push_back('{addr: 32'(k * 4), data: words[k]});
    end
    d0 = done_seen;
    send_word(csum, valid_pct);
    exp_done.push_back(exp_err);
    for (int i = 0; i < 10 && done_seen == d0; i++) @(posedge CLK);
    #1;
    if (done_seen == d0) fail_now("done_timeout", "no Done within 10 cycles");
    else lat = int'(done_cyc - s_cyc) + 1;
  endtask

  task automatic illegal_start(input logic [15:0] len);
    @(posedge CLK);
    #1;
    Loader_Start  = 1'b1;
    Loader_Length = len;
    exp_done.push_back(1'b1);
    @(posedge CLK);
    #1;
    Loader_Start = 1'b0;
    check("illegal_done", 32'(Loader_Done), 32'd1);
    check("illegal_error", 32'(Loader_Error), 32'd1);
    check("illegal_busy", 32'(Loader_Busy), 32'd0);
    @(posedge CLK);
    #1;
    check("illegal_done_one_cycle", 32'(Loader_Done), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, 32'(Loader_ByteReady), 32'd0);
    check({tag, "_wren"}, 32'(Loader_WrEn), 32'd0);
    check({tag, "_wraddr"}, Loader_WrAddr, 32'd0);
    check({tag, "_wrdata"}, Loader_WrData, 32'd0);
    check({tag, "_busy"}, 32'(Loader_Busy), 32'd0);
    check({tag, "_done"}, 32'(Loader_Done), 32'd0);
    check({tag, "_error"}, 32'(Loader_Error), 32'd0);
  endtask

  initial begin
    logic [31:0] words[$];
    logic [31:0] sum;
    int          lat;

    Loader_Start     = 1'b0;
    Loader_Length    = '0;
    Loader_ByteIn    = '0;
    Loader_ByteValid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outs("rst");
    @(negedge CLK);
    RST = 1'b0;

    // Nominal two-word load with minimum latency.
    words = '{32'h24010005, 32'h00000000};
    run_load(2, words, 32'h24010005, 100, 1'b0, lat);
    check("nominal_latency", 32'(lat), 32'd15);

    // Random gaps on Valid over a 3-word image.
    words.delete();
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      words.push_back($urandom);
      sum += words[i];
    end
    run_load(3, words, sum, 45, 1'b0, lat);

    // Checksum mismatch; Error must hold until the next Start.
    words = '{32'h8C220004};
    run_load(1, words, 32'h8C220005, 100, 1'b1, lat);
    repeat (3) @(posedge CLK);
    #1;
    check("error_holds", 32'(Loader_Error), 32'd1);
    check("idle_not_busy", 32'(Loader_Busy), 32'd0);

    illegal_start(16'd0);
    illegal_start(16'd101);

    // Full-depth load with large words so the sum wraps.
    words.delete();
    sum = '0;
    for (int i = 0; i < 100; i++) begin
      words.push_back($urandom | 32'h8000_0000);
      sum += words[i];
    end
    run_load(100, words, sum, 80, 1'b0, lat);
    check("last_write_addr", last_wr_addr, 32'h0000018C);

    // Reset after the 2nd byte of word 1.
    @(posedge CLK);
    #1;
    Loader_Start  = 1'b1;
    Loader_Length = 16'd2;
    @(posedge CLK);
    #1;
    Loader_Start = 1'b0;
    send_word(32'hDEADBEEF, 100);
    exp_wr.push_back('{addr: 32'h0, data: 32'hDEADBEEF});
    send_byte(8'h11, 100);
    send_byte(8'h22, 100);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outs("midrst");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_no_pending_write", 32'(exp_wr.size()), 32'd0);
    exp_wr.delete();
    repeat (3) @(posedge CLK);

    // Fresh load after reset.
    words.delete();
    sum = '0;
    for (int i = 0; i < 2; i++) begin
      words.push_back($urandom);
      sum += words[i];
    end
    run_load(2, words, sum, 100, 1'b0, lat);
    check("fresh_latency", 32'(lat), 32'd15);

    repeat (3) @(posedge CLK);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
